// File: rtl/glitch_delay.sv
// Trigger-to-glitch sequencer: once armed, waits a programmable number of cycles
// after a trigger, then drives a fixed-width glitch pulse and reports completion.
module glitch_delay #(
    parameter int unsigned GLITCH_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] delay,
    input  logic        set_delay,
    input  logic        arm,
    input  logic        abort,
    input  logic        trigger,
    output logic        glitch_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        DELAY  = 2'd2,
        GLITCH = 2'd3
    } state_t;

    // Counters hold "cycles remaining after this one", so zero means expire on this edge.
    localparam logic [15:0] WIDTH_RELOAD = 16'(GLITCH_WIDTH - 1);

    state_t      state, state_nxt;
    logic [31:0] delay_reg, delay_reg_nxt;
    logic [31:0] delay_cnt, delay_cnt_nxt;
    logic [15:0] width_cnt, width_cnt_nxt;
    logic        glitch_nxt, busy_nxt, done_nxt;
    logic        delay_zero, delay_expired, width_expired, config_open;

    assign delay_zero    = (delay_reg == 32'd0);
    assign delay_expired = (delay_cnt == 32'd0);
    assign width_expired = (width_cnt == 16'd0);
    assign config_open   = (state == IDLE) || (state == ARMED);

    always_comb begin
        state_nxt     = state;
        delay_reg_nxt = delay_reg;
        delay_cnt_nxt = delay_cnt;
        width_cnt_nxt = width_cnt;
        done_nxt      = 1'b0;

        if (set_delay && config_open)
            delay_reg_nxt = delay;

        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (arm)
                        state_nxt = ARMED;
                end
                ARMED: begin
                    // The trigger edge uses the delay held before any same-edge update.
                    if (trigger) begin
                        if (delay_zero) begin
                            state_nxt     = GLITCH;
                            width_cnt_nxt = WIDTH_RELOAD;
                        end else begin
                            state_nxt     = DELAY;
                            delay_cnt_nxt = delay_reg - 32'd1;
                        end
                    end
                end
                DELAY: begin
                    if (delay_expired) begin
                        state_nxt     = GLITCH;
                        width_cnt_nxt = WIDTH_RELOAD;
                    end else begin
                        delay_cnt_nxt = delay_cnt - 32'd1;
                    end
                end
                GLITCH: begin
                    if (width_expired) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        width_cnt_nxt = width_cnt - 16'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        glitch_nxt = (state_nxt == GLITCH);
        busy_nxt   = (state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            delay_reg  <= 32'd0;
            delay_cnt  <= 32'd0;
            width_cnt  <= 16'd0;
            glitch_out <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            delay_reg  <= delay_reg_nxt;
            delay_cnt  <= delay_cnt_nxt;
            width_cnt  <= width_cnt_nxt;
            glitch_out <= glitch_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule

// File: tb/tb_glitch_delay.sv
// Bench for glitch_delay: directed vector table, corner sequences, and random
// stimulus checked against a timestamp-based reference model.
module tb_glitch_delay;

    localparam int unsigned W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] delay = 32'd0;
    logic        set_delay = 1'b0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        trigger = 1'b0;
    logic        glitch_out, busy, done;

    glitch_delay #(.GLITCH_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .delay(delay), .set_delay(set_delay), .arm(arm),
        .abort(abort), .trigger(trigger), .glitch_out(glitch_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    longint unsigned cyc = 0;

    // Reference model: the glitch is a time window [start, end) in absolute edge numbers.
    int              m_mode = 0;   // 0 idle, 1 armed, 2 triggered
    logic [31:0]     m_dreg = 32'd0;
    longint unsigned m_start = 0, m_end = 0;
    logic            m_g = 1'b0, m_b = 1'b0, m_d = 1'b0;

    typedef struct {
        bit          r, sd;
        logic [31:0] dl;
        bit          ar, ab, tr;
        bit          eg, eb, ed;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit r, bit sd, logic [31:0] dl, bit ar, bit ab, bit tr,
                               bit eg, bit eb, bit ed);
        vec_t x;
        x.r = r; x.sd = sd; x.dl = dl; x.ar = ar; x.ab = ab; x.tr = tr;
        x.eg = eg; x.eb = eb; x.ed = ed;
        return x;
    endfunction

    task automatic model_step(bit r, bit sd, logic [31:0] dl, bit ar, bit ab, bit tr);
        logic [31:0] old;
        if (r) begin
            m_mode = 0; m_dreg = 32'd0; m_g = 1'b0; m_b = 1'b0; m_d = 1'b0;
            return;
        end
        m_d = 1'b0;
        old = m_dreg;
        if (sd && m_mode != 2) m_dreg = dl;
        if (ab) begin
            m_mode = 0;
        end else begin
            case (m_mode)
                0: if (ar) m_mode = 1;
                1: if (tr) begin
                       m_mode  = 2;
                       m_start = cyc + {32'd0, old};
                       m_end   = m_start + W;
                   end
                default: if (cyc == m_end) begin m_mode = 0; m_d = 1'b1; end
            endcase
        end
        m_g = (m_mode == 2) && (cyc >= m_start);
        m_b = (m_mode != 0);
    endtask

    task automatic drive(bit r, bit sd, logic [31:0] dl, bit ar, bit ab, bit tr);
        rst = r; set_delay = sd; delay = dl; arm = ar; abort = ab; trigger = tr;
        @(posedge clk);
        cyc++;
        model_step(r, sd, dl, ar, ab, tr);
        #1;
        rst = 1'b0; set_delay = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
    endtask

    task automatic chk(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic chk_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_model(string tag);
        chk({tag, ".glitch_out"}, glitch_out, m_g);
        chk({tag, ".busy"}, busy, m_b);
        chk({tag, ".done"}, done, m_d);
    endtask

    task automatic idle_step(string tag);
        drive(0, 0, 32'd0, 0, 0, 0);
        cmp_model(tag);
    endtask

    // Returns edges from trigger to the first glitch_out high, or -1 if not seen in bound.
    task automatic measure_rise(longint unsigned n0, string tag, output int lat);
        int k = 0;
        while (!glitch_out && k < 40) begin
            idle_step(tag);
            k++;
        end
        lat = glitch_out ? int'(cyc - n0) : -1;
    endtask

    task automatic wait_idle(string tag);
        int k = 0;
        while ((busy || done) && k < 40) begin
            idle_step(tag);
            k++;
        end
        chk({tag, ".idle_reached"}, busy | done, 1'b0);
    endtask

    initial begin
        longint unsigned n0;
        int lat, gcnt, dcnt;

        // Directed table: short delay run, zero delay with same-cycle set+arm,
        // arm right after done, abort mid-delay, abort priority, idle trigger.
        vecs.push_back(v(1,0,0,0,0,0, 0,0,0));
        vecs.push_back(v(0,1,5,0,0,0, 0,0,0));
        vecs.push_back(v(0,0,0,1,0,0, 0,1,0));
        vecs.push_back(v(0,0,0,0,0,1, 0,1,0));
        for (int i = 0; i < 4; i++) vecs.push_back(v(0,0,0,0,0,0, 0,1,0));
        for (int i = 0; i < 4; i++) vecs.push_back(v(0,0,0,0,0,0, 1,1,0));
        vecs.push_back(v(0,0,0,0,0,0, 0,0,1));
        vecs.push_back(v(0,0,0,0,0,0, 0,0,0));
        vecs.push_back(v(0,1,0,1,0,0, 0,1,0));
        vecs.push_back(v(0,0,0,0,0,1, 1,1,0));
        for (int i = 0; i < 3; i++) vecs.push_back(v(0,0,0,0,0,0, 1,1,0));
        vecs.push_back(v(0,0,0,0,0,0, 0,0,1));
        vecs.push_back(v(0,0,0,1,0,0, 0,1,0));
        vecs.push_back(v(0,0,0,0,1,0, 0,0,0));
        vecs.push_back(v(0,1,10,1,0,0, 0,1,0));
        vecs.push_back(v(0,0,0,0,0,1, 0,1,0));
        for (int i = 0; i < 2; i++) vecs.push_back(v(0,0,0,0,0,0, 0,1,0));
        vecs.push_back(v(0,0,0,0,1,0, 0,0,0));
        for (int i = 0; i < 14; i++) vecs.push_back(v(0,0,0,0,0,0, 0,0,0));
        vecs.push_back(v(0,0,0,1,1,0, 0,0,0));
        vecs.push_back(v(0,0,0,1,0,0, 0,1,0));
        vecs.push_back(v(0,0,0,0,1,1, 0,0,0));
        vecs.push_back(v(0,0,0,0,0,1, 0,0,0));

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].sd, vecs[i].dl, vecs[i].ar, vecs[i].ab, vecs[i].tr);
            chk($sformatf("vec%0d.glitch_out", i), glitch_out, vecs[i].eg);
            chk($sformatf("vec%0d.busy", i), busy, vecs[i].eb);
            chk($sformatf("vec%0d.done", i), done, vecs[i].ed);
        end

        // Triggers in IDLE and during DELAY are both dropped; exactly one glitch.
        drive(0, 1, 32'd3, 0, 0, 0);
        drive(0, 0, 32'd0, 0, 0, 1);
        cmp_model("ign_idle");
        drive(0, 0, 32'd0, 1, 0, 0);
        drive(0, 0, 32'd0, 0, 0, 1);
        drive(0, 0, 32'd0, 0, 0, 1);
        cmp_model("ign_delay");
        gcnt = 0; dcnt = 0;
        for (int i = 0; i < 14; i++) begin
            idle_step("ign_run");
            gcnt += int'(glitch_out);
            dcnt += int'(done);
        end
        chk_int("ign.glitch_cycles", gcnt, 4);
        chk_int("ign.done_pulses", dcnt, 1);

        // Reset mid-glitch clears delay_reg: next run fires with zero delay.
        drive(0, 1, 32'd5, 1, 0, 0);
        drive(0, 0, 32'd0, 0, 0, 1);
        n0 = cyc;
        measure_rise(n0, "rst_wait", lat);
        chk_int("rst.first_latency", lat, 5);
        idle_step("rst_mid");
        drive(1, 0, 32'd0, 0, 0, 0);
        chk("rst.glitch_out", glitch_out, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        drive(0, 0, 32'd0, 1, 0, 0);
        drive(0, 0, 32'd0, 0, 0, 1);
        chk("rst.zero_delay_rise", glitch_out, 1'b1);
        wait_idle("rst_tail");

        // set_delay during DELAY ignored; the retained value drives the next run too.
        drive(0, 1, 32'd6, 1, 0, 0);
        drive(0, 0, 32'd0, 0, 0, 1);
        n0 = cyc;
        drive(0, 1, 32'd2, 0, 0, 0);
        measure_rise(n0, "late_set", lat);
        chk_int("late_set.latency", lat, 6);
        wait_idle("late_set_tail");
        drive(0, 0, 32'd0, 1, 0, 0);
        drive(0, 0, 32'd0, 0, 0, 1);
        n0 = cyc;
        measure_rise(n0, "reuse", lat);
        chk_int("reuse.latency", lat, 6);
        wait_idle("reuse_tail");

        // Maximum delay: no wrap, so no glitch and still busy long after the trigger.
        drive(0, 1, 32'hFFFF_FFFF, 1, 0, 0);
        drive(0, 0, 32'd0, 0, 0, 1);
        for (int i = 0; i < 150; i++) idle_step("maxdly");
        chk("maxdly.busy", busy, 1'b1);
        drive(0, 0, 32'd0, 0, 1, 0);
        cmp_model("maxdly_abort");

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            bit r, sd, ar, ab, tr;
            logic [31:0] dl;
            r  = ($urandom_range(0, 199) == 0);
            ab = ($urandom_range(0, 39) == 0);
            ar = ($urandom_range(0, 4) == 0);
            tr = ($urandom_range(0, 3) == 0);
            sd = ($urandom_range(0, 9) == 0);
            dl = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 20))
                                             : 32'($urandom_range(0, 6));
            drive(r, sd, dl, ar, ab, tr);
            cmp_model("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
